// File: rtl/qadd_pkg.sv
// Shared definitions for the round-robin arbitrated fixed-point adder:
// default word format, output-slot state and the rotating priority search.
package qadd_pkg;

  localparam int unsigned DefaultN = 16;
  localparam int unsigned DefaultQ = 12;

  // Upper bound on requesters handled by rr_pick.
  localparam int unsigned MaxReq = 32;
  localparam int unsigned MaxIdw = 5;

  typedef enum logic [0:0] {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  typedef struct packed {
    logic              found;
    logic [MaxIdw-1:0] idx;
  } pick_t;

  // First set bit of valid[nreq-1:0], searching upward from ptr with wrap.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                    input int unsigned       ptr,
                                    input int unsigned       nreq);
    pick_t r;
    r = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < nreq && !r.found) begin
        int unsigned j;
        j = ptr + k;
        if (j >= nreq) j = j - nreq;
        if (valid[j[MaxIdw-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[MaxIdw-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/qadd_rr_arbiter_if.sv
// Request/result bundle between the requesters, the arbiter and the
// downstream consumer of sums.
interface qadd_rr_arbiter_if
  import qadd_pkg::*;
#(
  parameter int unsigned N    = DefaultN,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_c;
  logic [IDW-1:0]    res_id;
  logic              res_ovf;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_c, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_c, res_id, res_ovf
  );

endinterface

// File: rtl/qadd_rr_arbiter_qadd.sv
// Two's-complement wrap-around adder with signed-overflow detect; the binary
// point position does not affect the add.
module qadd #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         ovf
);

  always_comb begin
    c   = a + b;
    ovf = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]);
  end

endmodule

// File: rtl/qadd_rr_arbiter.sv
// Round-robin arbiter sharing one qadd among NREQ requesters, with a one-entry
// registered result slot that can pop and push on the same edge.
module qadd_rr_arbiter
  import qadd_pkg::*;
#(
  parameter int unsigned N    = DefaultN,
  parameter int unsigned Q    = DefaultQ,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               global_rst,
  qadd_rr_arbiter_if.slave  bus
);

  if (Q >= N || NREQ < 2 || NREQ > MaxReq) begin : g_param_check
    $error("qadd_rr_arbiter: unsupported parameter combination");
  end

  slot_state_e       state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]      c_q;
  logic [IDW-1:0]    id_q;
  logic              ovf_q;

  logic [MaxReq-1:0] valid_ext;
  pick_t             pick;
  logic              can_accept;
  logic              xfer;
  logic [N-1:0]      a_sel, b_sel, sum;
  logic              sum_ovf;

  // Grant: the ready path is purely combinational from req_valid/res_ready.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = bus.req_valid;
    pick                  = rr_pick(valid_ext, 32'(ptr_q), NREQ);
    can_accept            = (state_q == SLOT_EMPTY) || bus.res_ready;
    xfer                  = pick.found && can_accept && !global_rst;
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_ready[i] = xfer && (pick.idx == MaxIdw'(i));
    end
  end

  // Operand mux so that a single adder serves every requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick.idx == MaxIdw'(i)) begin
        a_sel = bus.req_a[i*N +: N];
        b_sel = bus.req_b[i*N +: N];
      end
    end
  end

  qadd #(
    .N (N)
  ) u_qadd (
    .a   (a_sel),
    .b   (b_sel),
    .c   (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      SLOT_EMPTY: if (xfer) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (xfer) state_d = SLOT_FULL;
        else if (bus.res_ready) state_d = SLOT_EMPTY;
      end
    endcase
    if (xfer) begin
      ptr_d = (pick.idx == MaxIdw'(NREQ - 1)) ? '0 : IDW'(pick.idx + MaxIdw'(1));
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      c_q     <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        c_q   <= sum;
        id_q  <= pick.idx[IDW-1:0];
        ovf_q <= sum_ovf;
      end
    end
  end

  always_comb begin
    bus.res_valid = (state_q == SLOT_FULL);
    bus.res_c     = c_q;
    bus.res_id    = id_q;
    bus.res_ovf   = ovf_q;
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (global_rst)
    $onehot0(bus.req_ready));

  a_stall_stable: assert property (@(posedge clk) disable iff (global_rst)
    bus.res_valid && !bus.res_ready |=> bus.res_valid && $stable(bus.res_c) &&
                                        $stable(bus.res_id) && $stable(bus.res_ovf));

endmodule
